countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable 8-bit down-counter with a programmable prescaler.
- Accepts a start value over a valid/ready handshake and counts down to zero.
- Reports terminal count over a held valid/ready "done" handshake.
- Terminal detection uses the existing equal_zero block on the count register. This block is the sequential consumer of equal_zero's flag.

Parameters:
- PRESCALE, 4: clock cycles per decrement. Legal range 1..256; 1 means one decrement per cycle.
- AUTO_RELOAD, 0: when 1, a completed count reloads the last loaded value and restarts on done acceptance.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_load_valid  in  1  start request.
- i_load_value  in  8  start value.
- o_load_ready  out  1  block can accept a load.
- i_abort  in  1  cancel the current count.
- i_done_ready  in  1  consumer accepts done.
- o_done_valid  out  1  terminal count reached, held until accepted.
- o_busy  out  1  counting.
- o_count  out  8  current count register.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=IDLE; count, prescaler and reload registers = 0.
  - Outputs: o_load_ready=1, o_done_valid=0, o_busy=0, o_count=0.
  - Loads are never accepted while i_rst=1.
- States: IDLE, RUN, DONE. Outputs are decoded from registered state only:
  - o_load_ready = (state==IDLE)
  - o_busy = (state==RUN)
  - o_done_valid = (state==DONE)
- IDLE:
  - i_abort is ignored.
  - On i_load_valid && o_load_ready: count <= i_load_value, reload <= i_load_value, prescaler <= 0, state <= RUN.
- RUN:
  - If the zero flag (equal_zero on count) is 1: state <= DONE. Count stays 0.
  - Otherwise the prescaler increments each cycle. When prescaler==PRESCALE-1: prescaler <= 0 and count <= count-1.
- Latency: a load of N accepted at edge t gives o_count=N after edge t+1. Each subsequent value appears PRESCALE cycles later; 0 appears at t+1+N*PRESCALE. o_done_valid rises at t+2+N*PRESCALE.
- Load of 0: enters RUN and reaches DONE one cycle later (done at t+2). There is no special path.
- No wrap-around: count never decrements below 0.
- DONE:
  - o_done_valid is held and o_count=0.
  - On i_done_ready with AUTO_RELOAD=0: state <= IDLE.
  - On i_done_ready with AUTO_RELOAD=1: count <= reload, prescaler <= 0, state <= RUN.
- Abort, in RUN or DONE: next state is IDLE, count <= 0, prescaler <= 0, and no done is issued.
  - Abort has priority over the done handshake and over auto-reload.
- Load during RUN or DONE is not accepted (ready=0). The upstream holds valid.
- Prescaler width is clog2(PRESCALE), minimum 1 bit.

Decomposition:
- Shared include file countdown_defs.vh holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - COUNT_W=8
- One sub-module: equal_zero, instantiated once on the count register. No other sub-modules.

Test Plan:
1. PRESCALE=4, load 3 at edge 0 -> o_count 3@1, 2@5, 1@9, 0@13; o_done_valid=1 @14; o_busy=1 for cycles 1-13.
2. Load 0 -> o_busy=1 @1; o_done_valid=1 @2; o_count stays 0.
3. In DONE, hold i_done_ready=0 for 10 cycles -> o_done_valid stays 1 and o_load_ready stays 0. Raise ready -> IDLE next cycle; a new load of 7 is then accepted.
4. AUTO_RELOAD=1, PRESCALE=1, load 2 at edge 0 -> count 2@1, 1@2, 0@3; done@4. Accept at 4 -> count 2@5, done again @8.
5. Abort at count 5 in RUN -> IDLE, o_count=0, no done pulse. Abort together with i_done_ready in DONE, with AUTO_RELOAD=1 -> IDLE, no reload.
6. Assert i_rst asynchronously mid-RUN at count 9 -> all outputs at reset values before the next clock edge. A load presented during reset is ignored.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// ----------------------------------------------------------------------------
// countdown_timer_pkg
//
// Shared definitions for the countdown timer slice: count width, FSM state
// encoding and the decode from state to the handshake/status outputs.
//
// Contents:
//   COUNT_W          width of the count and reload registers
//   state_t          IDLE=2'd0, RUN=2'd1, DONE=2'd2
//   status_t         {load_ready, busy, done_valid} output bundle
//   decode_status()  status outputs implied by a given state
//   prescale_width() prescaler register width, never less than 1 bit
// ----------------------------------------------------------------------------
package countdown_timer_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic load_ready;
        logic busy;
        logic done_valid;
    } status_t;

    // The status outputs are a pure function of the state being entered, so
    // the FSM registers them alongside the state and they never glitch.
    function automatic status_t decode_status(state_t st);
        status_t s;
        s.load_ready = (st == ST_IDLE);
        s.busy       = (st == ST_RUN);
        s.done_valid = (st == ST_DONE);
        return s;
    endfunction

    // PRESCALE of 1 or 2 still needs a 1-bit register; $clog2 would give 0
    // for PRESCALE=1.
    function automatic int prescale_width(int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/equal_zero.sv
// ----------------------------------------------------------------------------
// equal_zero
//
// Combinational zero detector. Used by the countdown timer on its count
// register; the timer FSM is the only (sequential) consumer of the flag.
//
// Parameters:
//   WIDTH    width of the compared value
// Ports:
//   value    in  WIDTH  value under test
//   is_zero  out 1      1 when value is all zeros
// ----------------------------------------------------------------------------
module equal_zero
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic [WIDTH-1:0] value,
    output logic             is_zero
);

    assign is_zero = (value == '0);

endmodule

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
//
// Loadable 8-bit down-counter with a programmable prescaler. A start value is
// taken over a valid/ready handshake, the count decrements once every
// PRESCALE clocks down to zero, and terminal count is then reported on a
// held valid/ready "done" handshake. With AUTO_RELOAD=1 accepting done
// reloads the last loaded value and counts again.
//
// Parameters:
//   PRESCALE     clocks per decrement, 1..256 (1 = decrement every clock)
//   AUTO_RELOAD  1 = restart from the last loaded value on done acceptance
//
// Ports:
//   i_clk         in  1  clock, rising edge
//   i_rst         in  1  asynchronous reset, active-high
//   i_load_valid  in  1  start request
//   i_load_value  in  8  start value
//   o_load_ready  out 1  block can accept a load (IDLE)
//   i_abort       in  1  cancel the current count (RUN or DONE)
//   i_done_ready  in  1  consumer accepts done
//   o_done_valid  out 1  terminal count reached, held until accepted
//   o_busy        out 1  counting (RUN)
//   o_count       out 8  current count register
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a load; o_load_ready=1
//   RUN     | prescaling and decrementing toward zero; o_busy=1
//   DONE    | count reached zero; o_done_valid held until i_done_ready
// ----------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE    = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_valid,
    input  logic [COUNT_W-1:0] i_load_value,
    output logic               o_load_ready,
    input  logic               i_abort,
    input  logic               i_done_ready,
    output logic               o_done_valid,
    output logic               o_busy,
    output logic [COUNT_W-1:0] o_count
);

    localparam int            PS_W    = prescale_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] reload;
    logic [PS_W-1:0]    prescaler;
    logic               count_zero;

    equal_zero #(
        .WIDTH   (COUNT_W)
    ) u_equal_zero (
        .value   (count),
        .is_zero (count_zero)
    );

    assign o_count = count;

    // Terminal detection happens one clock after the count reaches zero,
    // because the FSM acts on the registered count through equal_zero. A
    // load of 0 therefore spends exactly one clock in RUN, with no special
    // path. Because the zero check precedes the decrement, count never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            reload    <= '0;
            prescaler <= '0;
            {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    // Abort has nothing to cancel here and is ignored.
                    if (i_load_valid && o_load_ready) begin
                        count     <= i_load_value;
                        reload    <= i_load_value;
                        prescaler <= '0;
                        state     <= ST_RUN;
                        {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_RUN);
                    end
                end

                ST_RUN: begin
                    if (i_abort) begin
                        count     <= '0;
                        prescaler <= '0;
                        state     <= ST_IDLE;
                        {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_IDLE);
                    end else if (count_zero) begin
                        state <= ST_DONE;
                        {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_DONE);
                    end else if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        count     <= count - COUNT_W'(1);
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end

                ST_DONE: begin
                    // Abort outranks both the done handshake and auto-reload.
                    if (i_abort) begin
                        count     <= '0;
                        prescaler <= '0;
                        state     <= ST_IDLE;
                        {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_IDLE);
                    end else if (i_done_ready) begin
                        if (AUTO_RELOAD) begin
                            count     <= reload;
                            prescaler <= '0;
                            state     <= ST_RUN;
                            {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_RUN);
                        end else begin
                            state <= ST_IDLE;
                            {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_IDLE);
                        end
                    end
                end

                default: begin
                    count     <= '0;
                    prescaler <= '0;
                    state     <= ST_IDLE;
                    {o_load_ready, o_busy, o_done_valid} <= decode_status(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
//
// Two timer instances: dut_a (PRESCALE=4, AUTO_RELOAD=0) and dut_b
// (PRESCALE=1, AUTO_RELOAD=1). Stimulus pushes expected status samples
// (cycle, instance, {ready,busy,done,count}) and expected done-rise cycles
// into queues; a monitor on the falling edge pops and compares them.
// Cycle k means "after the k-th rising edge". A load driven just after edge
// t is sampled at edge t+1 and shows its value after edge t+1.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       load_valid_a, load_valid_b;
    logic [7:0] load_value_a, load_value_b;
    logic       abort_a, abort_b;
    logic       done_ready_a, done_ready_b;
    logic       load_ready_a, load_ready_b;
    logic       done_valid_a, done_valid_b;
    logic       busy_a, busy_b;
    logic [7:0] count_a, count_b;

    countdown_timer #(
        .PRESCALE     (4),
        .AUTO_RELOAD  (1'b0)
    ) dut_a (
        .i_clk        (clk),
        .i_rst        (rst_a),
        .i_load_valid (load_valid_a),
        .i_load_value (load_value_a),
        .o_load_ready (load_ready_a),
        .i_abort      (abort_a),
        .i_done_ready (done_ready_a),
        .o_done_valid (done_valid_a),
        .o_busy       (busy_a),
        .o_count      (count_a)
    );

    countdown_timer #(
        .PRESCALE     (1),
        .AUTO_RELOAD  (1'b1)
    ) dut_b (
        .i_clk        (clk),
        .i_rst        (rst_b),
        .i_load_valid (load_valid_b),
        .i_load_value (load_value_b),
        .o_load_ready (load_ready_b),
        .i_abort      (abort_b),
        .i_done_ready (done_ready_b),
        .o_done_valid (done_valid_b),
        .o_busy       (busy_b),
        .o_count      (count_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          dut;
        string       name;
        logic [10:0] exp;   // {ready, busy, done, count}
    } exp_t;

    exp_t exp_q[$];
    int   done_q_a[$];
    int   done_q_b[$];
    bit   stim_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic expect_at(input int c, input int d, input string nm,
                             input logic [7:0] cnt, input logic rdy,
                             input logic bsy, input logic dn);
        exp_t e;
        e.cyc  = c;
        e.dut  = d;
        e.name = nm;
        e.exp  = {rdy, bsy, dn, cnt};
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t0, t1, t;
        rst_a = 1'b1; rst_b = 1'b1;
        load_valid_a = 1'b0; load_valid_b = 1'b0;
        load_value_a = 8'd0; load_value_b = 8'd0;
        abort_a = 1'b0; abort_b = 1'b0;
        done_ready_a = 1'b0; done_ready_b = 1'b0;

        expect_at(1, 0, "reset_a", 8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(1, 1, "reset_b", 8'd0, 1'b1, 1'b0, 1'b0);
        step(2);
        rst_a = 1'b0; rst_b = 1'b0;
        step(1);

        // Load 3, PRESCALE=4
        t0 = cyc;
        load_value_a = 8'd3; load_valid_a = 1'b1;
        expect_at(t0 + 1,  0, "t1_cnt3",      8'd3, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 4,  0, "t1_cnt3_hold", 8'd3, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 5,  0, "t1_cnt2",      8'd2, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 9,  0, "t1_cnt1",      8'd1, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 12, 0, "t1_cnt1_hold", 8'd1, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 13, 0, "t1_cnt0_busy", 8'd0, 1'b0, 1'b1, 1'b0);
        expect_at(t0 + 14, 0, "t1_done",      8'd0, 1'b0, 1'b0, 1'b1);
        expect_at(t0 + 5,  1, "b_idle",       8'd0, 1'b1, 1'b0, 1'b0);
        done_q_a.push_back(t0 + 14);
        step(1);
        load_valid_a = 1'b0;

        // Done held for 10 cycles, a pending load is refused until IDLE
        for (int k = 1; k <= 10; k++)
            expect_at(t0 + 14 + k, 0, "t3_done_held", 8'd0, 1'b0, 1'b0, 1'b1);
        wait_until(t0 + 20);
        load_value_a = 8'd7; load_valid_a = 1'b1;
        wait_until(t0 + 24);
        done_ready_a = 1'b1;
        expect_at(t0 + 25, 0, "t3_idle",  8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(t0 + 26, 0, "t3_load7", 8'd7, 1'b0, 1'b1, 1'b0);
        step(1);
        done_ready_a = 1'b0;
        step(1);
        load_valid_a = 1'b0;

        // Abort at count 5
        t1 = t0 + 26;
        expect_at(t1 + 4, 0, "t5_cnt6", 8'd6, 1'b0, 1'b1, 1'b0);
        expect_at(t1 + 8, 0, "t5_cnt5", 8'd5, 1'b0, 1'b1, 1'b0);
        wait_until(t1 + 8);
        abort_a = 1'b1;
        expect_at(t1 + 9, 0, "t5_abort_idle", 8'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        abort_a = 1'b0;
        expect_at(t1 + 30, 0, "t5_no_done", 8'd0, 1'b1, 1'b0, 1'b0);
        wait_until(t1 + 31);

        // Load 0
        t = cyc;
        load_value_a = 8'd0; load_valid_a = 1'b1;
        expect_at(t + 1, 0, "t2_busy", 8'd0, 1'b0, 1'b1, 1'b0);
        expect_at(t + 2, 0, "t2_done", 8'd0, 1'b0, 1'b0, 1'b1);
        done_q_a.push_back(t + 2);
        step(1);
        load_valid_a = 1'b0;
        step(1);
        done_ready_a = 1'b1;
        expect_at(t + 3, 0, "t2_idle", 8'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        done_ready_a = 1'b0;

        // Asynchronous reset mid-RUN at count 9, load offered during reset
        t = cyc;
        load_value_a = 8'd9; load_valid_a = 1'b1;
        expect_at(t + 1, 0, "t6_cnt9", 8'd9, 1'b0, 1'b1, 1'b0);
        step(1);
        load_valid_a = 1'b0;
        step(1);
        #2;
        rst_a = 1'b1;
        load_value_a = 8'd5; load_valid_a = 1'b1;
        expect_at(t + 2, 0, "t6_async_rst",        8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(t + 3, 0, "t6_rst_load_ignored", 8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(t + 4, 0, "t6_rst_load_ignored", 8'd0, 1'b1, 1'b0, 1'b0);
        step(2);
        rst_a = 1'b0; load_valid_a = 1'b0;
        expect_at(t + 5, 0, "t6_after_rst",  8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(t + 8, 0, "t6_still_idle", 8'd0, 1'b1, 1'b0, 1'b0);
        step(8);

        // Auto-reload, PRESCALE=1
        t = cyc;
        load_value_b = 8'd2; load_valid_b = 1'b1;
        expect_at(t + 1, 1, "t4_cnt2", 8'd2, 1'b0, 1'b1, 1'b0);
        expect_at(t + 2, 1, "t4_cnt1", 8'd1, 1'b0, 1'b1, 1'b0);
        expect_at(t + 3, 1, "t4_cnt0", 8'd0, 1'b0, 1'b1, 1'b0);
        expect_at(t + 4, 1, "t4_done", 8'd0, 1'b0, 1'b0, 1'b1);
        done_q_b.push_back(t + 4);
        step(1);
        load_valid_b = 1'b0;
        wait_until(t + 4);
        done_ready_b = 1'b1;
        expect_at(t + 5, 1, "t4_reload_cnt2", 8'd2, 1'b0, 1'b1, 1'b0);
        expect_at(t + 6, 1, "t4_reload_cnt1", 8'd1, 1'b0, 1'b1, 1'b0);
        expect_at(t + 7, 1, "t4_reload_cnt0", 8'd0, 1'b0, 1'b1, 1'b0);
        expect_at(t + 8, 1, "t4_done_again",  8'd0, 1'b0, 1'b0, 1'b1);
        done_q_b.push_back(t + 8);
        step(1);
        done_ready_b = 1'b0;

        // Abort together with done_ready, auto-reload enabled
        wait_until(t + 8);
        abort_b = 1'b1; done_ready_b = 1'b1;
        expect_at(t + 9,  1, "t5_abort_no_reload", 8'd0, 1'b1, 1'b0, 1'b0);
        expect_at(t + 12, 1, "t5_abort_idle_b",    8'd0, 1'b1, 1'b0, 1'b0);
        step(1);
        abort_b = 1'b0; done_ready_b = 1'b0;
        wait_until(t + 13);

        stim_done = 1'b1;
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    bit prev_done_a = 1'b0;
    bit prev_done_b = 1'b0;

    always @(negedge clk) begin
        logic [10:0] act;
        int          exp_c;
        if (!stim_done) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc <= cyc) begin
                    act = (exp_q[i].dut == 0) ?
                          {load_ready_a, busy_a, done_valid_a, count_a} :
                          {load_ready_b, busy_b, done_valid_b, count_b};
                    n_checks++;
                    if (exp_q[i].cyc != cyc) begin
                        n_fail++;
                        $display("FAIL %s: due at cycle %0d, sampled late at cycle %0d",
                                 exp_q[i].name, exp_q[i].cyc, cyc);
                    end else if (act !== exp_q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s cycle %0d: got ready/busy/done/count=%b/%b/%b/%0d, want %b/%b/%b/%0d",
                                 exp_q[i].name, cyc, act[10], act[9], act[8], act[7:0],
                                 exp_q[i].exp[10], exp_q[i].exp[9], exp_q[i].exp[8],
                                 exp_q[i].exp[7:0]);
                    end
                    exp_q.delete(i);
                end
            end

            if (done_valid_a && !prev_done_a) begin
                n_checks++;
                if (done_q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done_a: done rose at cycle %0d, none expected", cyc);
                end else begin
                    exp_c = done_q_a.pop_front();
                    if (exp_c != cyc) begin
                        n_fail++;
                        $display("FAIL done_cycle_a: rose at cycle %0d, want %0d", cyc, exp_c);
                    end
                end
            end
            if (done_valid_b && !prev_done_b) begin
                n_checks++;
                if (done_q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done_b: done rose at cycle %0d, none expected", cyc);
                end else begin
                    exp_c = done_q_b.pop_front();
                    if (exp_c != cyc) begin
                        n_fail++;
                        $display("FAIL done_cycle_b: rose at cycle %0d, want %0d", cyc, exp_c);
                    end
                end
            end
            prev_done_a = done_valid_a;
            prev_done_b = done_valid_b;
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: sample for cycle %0d never taken", exp_q[i].name, exp_q[i].cyc);
            end
            foreach (done_q_a[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_done_a: got no done rise, want one at cycle %0d", done_q_a[i]);
            end
            foreach (done_q_b[i]) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_done_b: got no done rise, want one at cycle %0d", done_q_b[i]);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
